// File: rtl/cfg_frame_writer_pkg.sv
// rtl/cfg_frame_writer_pkg.sv - shared types, defaults and memory-size helpers for cfg_frame_writer
package cfg_frame_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_FINISH = 3'd5
    } cfg_state_e;

    localparam int unsigned DEF_NUM_MEMS     = 10;
    localparam int unsigned DEF_BITS_PER_MEM = 6;
    localparam int unsigned DEF_SHORT_BITS   = 2;
    localparam logic [63:0] DEF_SHORT_MASK   = 64'h2;

    // Number of bits held by memory idx: short memories are flagged in mask.
    function automatic int unsigned mem_bits(input logic [63:0] mask,
                                             input logic [5:0]  idx,
                                             input int unsigned short_bits,
                                             input int unsigned full_bits);
        return mask[idx] ? short_bits : full_bits;
    endfunction

    function automatic int unsigned total_bits(input logic [63:0] mask,
                                               input int unsigned num_mems,
                                               input int unsigned short_bits,
                                               input int unsigned full_bits);
        int unsigned t;
        t = 0;
        for (int i = 0; i < int'(num_mems); i++) begin
            t += mem_bits(mask, 6'(i), short_bits, full_bits);
        end
        return t;
    endfunction

    // Bits in a block built with the default geometry (9*6 + 2).
    localparam int unsigned TOTAL_BITS =
        total_bits(DEF_SHORT_MASK, DEF_NUM_MEMS, DEF_SHORT_BITS, DEF_BITS_PER_MEM);

endpackage

// File: rtl/cfg_frame_writer_addr_counter.sv
// rtl/cfg_frame_writer_addr_counter.sv - nested bit/memory index counter for the frame writer
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   clear           return both indices to memory 0, bit 0
//   advance         step to the next bit (wrapping into the next memory)
//   bit_idx         current bit index within the memory
//   mem_idx         current memory index
//   last            current position is the final bit of the final memory
module cfg_addr_counter
    import cfg_frame_writer_pkg::*;
#(
    parameter int                  NUM_MEMS     = 10,
    parameter int                  BITS_PER_MEM = 6,
    parameter int                  SHORT_BITS   = 2,
    parameter logic [NUM_MEMS-1:0] SHORT_MASK   = 10'b0000000010,
    parameter int                  ADDR_LO_W    = 3,
    parameter int                  ADDR_HI_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    output logic [ADDR_LO_W-1:0] bit_idx,
    output logic [ADDR_HI_W-1:0] mem_idx,
    output logic                 last
);

    int unsigned limit;
    logic        bit_end;

    always_comb begin
        limit   = mem_bits(64'(SHORT_MASK), 6'(mem_idx), SHORT_BITS, BITS_PER_MEM);
        bit_end = (32'(bit_idx) == limit - 1);
        // Termination by explicit compare keeps unused decoder codes undriven.
        last    = bit_end && (32'(mem_idx) == NUM_MEMS - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= '0;
            mem_idx <= '0;
        end else if (clear) begin
            bit_idx <= '0;
            mem_idx <= '0;
        end else if (advance) begin
            if (last) begin
                bit_idx <= '0;
                mem_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= '0;
                mem_idx <= mem_idx + ADDR_HI_W'(1);
            end else begin
                bit_idx <= bit_idx + ADDR_LO_W'(1);
            end
        end
    end

endmodule

// File: rtl/cfg_frame_writer.sv
// rtl/cfg_frame_writer.sv - serial bitstream to frame-port writer for one routing block
//
// Ports:
//   prog_clk   configuration clock
//   pReset     asynchronous active-high reset
//   start      one-cycle pulse, begins a full-block write when idle
//   bs_valid   bitstream bit available
//   bs_data    bitstream bit
//   bs_ready   writer accepts bs_data this cycle (high only while fetching)
//   enable     decoder enable strobe, one cycle per bit
//   address    {memory index, bit index}
//   data_in    bit being written
//   busy       high from start acceptance until done
//   done       one-cycle pulse after the final bit's hold cycle
module cfg_frame_writer
    import cfg_frame_writer_pkg::*;
#(
    parameter int                  NUM_MEMS     = 10,
    parameter int                  BITS_PER_MEM = 6,
    parameter int                  SHORT_BITS   = 2,
    parameter logic [NUM_MEMS-1:0] SHORT_MASK   = 10'b0000000010,
    parameter int                  ADDR_LO_W    = 3,
    parameter int                  ADDR_HI_W    = 4
) (
    input  logic                           prog_clk,
    input  logic                           pReset,
    input  logic                           start,
    input  logic                           bs_valid,
    input  logic                           bs_data,
    output logic                           bs_ready,
    output logic                           enable,
    output logic [ADDR_LO_W+ADDR_HI_W-1:0] address,
    output logic                           data_in,
    output logic                           busy,
    output logic                           done
);

    cfg_state_e             state;
    logic [ADDR_LO_W-1:0]   bit_idx;
    logic [ADDR_HI_W-1:0]   mem_idx;
    logic                   last;
    logic                   cnt_clear;
    logic                   cnt_advance;

    assign cnt_clear   = (state == ST_IDLE) && start;
    assign cnt_advance = (state == ST_HOLD);

    cfg_addr_counter #(
        .NUM_MEMS     (NUM_MEMS),
        .BITS_PER_MEM (BITS_PER_MEM),
        .SHORT_BITS   (SHORT_BITS),
        .SHORT_MASK   (SHORT_MASK),
        .ADDR_LO_W    (ADDR_LO_W),
        .ADDR_HI_W    (ADDR_HI_W)
    ) u_cnt (
        .clk     (prog_clk),
        .rst     (pReset),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .bit_idx (bit_idx),
        .mem_idx (mem_idx),
        .last    (last)
    );

    // bs_ready and enable are registered copies of "next state is FETCH" and
    // "next state is STROBE", so each is high exactly while in that state.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state    <= ST_IDLE;
            bs_ready <= 1'b0;
            enable   <= 1'b0;
            address  <= '0;
            data_in  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        busy     <= 1'b1;
                        bs_ready <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (bs_valid && bs_ready) begin
                        data_in  <= bs_data;
                        address  <= {mem_idx, bit_idx};
                        bs_ready <= 1'b0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    enable <= 1'b1;
                    state  <= ST_STROBE;
                end
                ST_STROBE: begin
                    enable <= 1'b0;
                    state  <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (last) begin
                        state <= ST_FINISH;
                    end else begin
                        state    <= ST_FETCH;
                        bs_ready <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    address <= '0;
                    data_in <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    bs_ready <= 1'b0;
                    enable   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cfg_frame_writer.md
Name: cfg_frame_writer

Overview:
- Configuration-side initiator for frame-addressed routing blocks such as connection blocks, where a per-block decoder selects one mux memory and that memory's bit address selects one cell.
- Consumes a serial bitstream over a valid/ready handshake.
- Walks every memory and every bit in order, driving enable/address/data_in with setup/strobe/hold timing.
- One instance sits on the programming side of each block's frame port; asserts done when the block is fully written.

Parameters:
NUM_MEMS, 10, mux memories behind the block decoder (decoder outputs 0..NUM_MEMS-1)
BITS_PER_MEM, 6, bits in a full-size mux memory
SHORT_BITS, 2, bits in a short memory (size-2 mux)
SHORT_MASK, 10'b0000000010, bit i set means memory i has SHORT_BITS bits
ADDR_LO_W, 3, bit-address field width, >= clog2(BITS_PER_MEM)
ADDR_HI_W, 4, memory-select field width, >= clog2(NUM_MEMS)

Ports:
prog_clk  in  1  configuration clock; the only clock
pReset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a full-block write when idle
bs_valid  in  1  bitstream bit available
bs_data  in  1  bitstream bit
bs_ready  out  1  writer accepts bs_data this cycle
enable  out  1  decoder enable strobe to the block
address  out  ADDR_LO_W+ADDR_HI_W  address[0:ADDR_LO_W-1] = bit index, LSB on address[0]; upper field = memory index, LSB on address[ADDR_LO_W]
data_in  out  1  bit being written
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the final bit's hold cycle

Behaviour:
- Reset values (async on pReset): enable=0, address=0, data_in=0, bs_ready=0, busy=0, done=0, FSM=IDLE, counters=0.
- Clock and reset: prog_clk and pReset, reset asynchronous and active-high, as fixed.
- All outputs are registered.
- FSM states: IDLE, FETCH, SETUP, STROBE, HOLD, FINISH.
  - IDLE: start=1 -> FETCH, busy<=1, mem_idx=0, bit_idx=0. start while busy is ignored (no restart, no error).
  - FETCH: bs_ready=1 (combinational from state). On bs_valid&bs_ready, latch data_in<=bs_data, address<={mem_idx,bit_idx} -> SETUP. Stalls indefinitely while bs_valid=0; outputs hold.
  - SETUP: enable=0; address/data stable for one full cycle -> STROBE.
  - STROBE: enable=1 for exactly one cycle -> HOLD.
  - HOLD: enable=0, address/data still held. Advance counters:
    - bit_idx+1 while < limit-1, where limit = SHORT_BITS if SHORT_MASK[mem_idx], else BITS_PER_MEM.
    - Otherwise bit_idx=0 and mem_idx+1.
    - If mem_idx==NUM_MEMS-1 and bit_idx==limit-1 -> FINISH; else -> FETCH.
  - FINISH: done=1 for one cycle, busy<=0, address<=0, data_in<=0 -> IDLE.
- Timing:
  - Minimum 4 cycles per bit (FETCH, SETUP, STROBE, HOLD) with bs_valid held high.
  - Total bits = sum of memory sizes; default 9*6+2 = 56 bits.
  - Default run with no stalls: start accepted at cycle 0, done at cycle 1+56*4 = 225.
- Protocol invariants:
  - address never changes in the cycle enable=1 or the cycle either side of it.
  - enable is never high outside STROBE.
  - Exactly one enable pulse per bitstream bit.
  - Bits past the total are not consumed: bs_ready=0 outside FETCH.
- Counters: bit_idx is ADDR_LO_W wide and mem_idx is ADDR_HI_W wide, with no wrap-around. Termination is by explicit compare, so unused decoder codes (10..15) are never driven.
- pReset mid-run:
  - enable drops immediately (asynchronous); partial configuration is abandoned.
  - A new start begins again at memory 0, bit 0.

Decomposition:
- Shared package: a cfg_state_e enum (IDLE..FINISH) plus localparam TOTAL_BITS, and a function mem_bits(idx) returning the per-memory limit from SHORT_MASK.
- One natural sub-module, cfg_addr_counter: the bit/memory nested counter with limit lookup and a last-bit flag. The FSM and handshake stay in the top module.

Test Plan:
- Default parameters, bs_valid held 1, bitstream alternating 1,0,…: exactly 56 enable pulses and done at cycle 225 after start.
  - Pulse k has data_in = k%2.
  - Address sequence: 0..5 with memory 0, then 0..1 with memory 1, then 0..5 with memories 2..9.
- Random bs_valid deassertion (30%): same address/data sequence as the first scenario, bs_ready only in FETCH, enable never high while bs_valid has stalled the FSM in FETCH; done after all 56 bits.
- Protocol monitor throughout: address and data_in equal their values from the prior and next cycle whenever enable=1; enable width is exactly 1 cycle.
- start pulsed again at bit 20 while busy: ignored; sequence and pulse count unchanged.
- pReset asserted mid-STROBE at bit 30: enable, busy and address go to 0 without a clock edge. Restart writes from address 0 / memory 0, 56 pulses.
- SHORT_MASK=0, NUM_MEMS=1, BITS_PER_MEM=1: one bit written, done pulses 5 cycles after start, address always 0.
